// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one multi-cycle ALU between two requesters. Round-robin arbitration
// is done in IDLE. The winning request's payload is latched and issued to the
// ALU as a one-cycle strobe. Completion is returned to the owner as a
// one-cycle done pulse with a registered result. Every wait state is bounded
// by a cycle counter; when the counter expires, timeout_err pulses and the
// transaction is dropped.
//
// Ports
//   clk, rst            clock (posedge) / asynchronous active-high reset
//   reqN_valid/ready    request handshake, N = 0,1 (ready only in IDLE)
//   reqN_op/a/b         request payload
//   reqN_done/result    one-cycle completion pulse and held result
//   alu_ready           ALU idle
//   alu_valid           one-cycle issue strobe
//   alu_op/a/b          issued payload, held while the operation runs
//   alu_done/result     ALU completion, only observed in WAIT_DONE
//   busy                FSM not in IDLE
//   grant               index of the current/last owner
//   timeout_err         one-cycle pulse when a wait state times out
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | arbitrate; ready offered while ALU idle
// ISSUE     | alu_valid high for one cycle with latched payload
// WAIT_ACK  | wait for ALU to drop alu_ready (operation taken)
// WAIT_DONE | ops 1..4: wait for alu_done, capture result
// WAIT_RDY  | wait for alu_ready to return; other ops complete here
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int OP_WIDTH     = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int TIMEOUT      = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [2:0]              req0_op,
  input  logic [OP_WIDTH-1:0]     req0_a,
  input  logic [OP_WIDTH-1:0]     req0_b,
  output logic                    req0_done,
  output logic [RESULT_WIDTH-1:0] req0_result,

  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [2:0]              req1_op,
  input  logic [OP_WIDTH-1:0]     req1_a,
  input  logic [OP_WIDTH-1:0]     req1_b,
  output logic                    req1_done,
  output logic [RESULT_WIDTH-1:0] req1_result,

  input  logic                    alu_ready,
  output logic                    alu_valid,
  output logic [2:0]              alu_op,
  output logic [OP_WIDTH-1:0]     alu_a,
  output logic [OP_WIDTH-1:0]     alu_b,
  input  logic                    alu_done,
  input  logic [RESULT_WIDTH-1:0] alu_result,

  output logic                    busy,
  output logic                    grant,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    WAIT_RDY
  } state_t;

  state_t                  state_q, state_d;

  // last_q = index of the requester served most recently; the other one
  // has priority on a tie. Reset value 1 makes req0 win the first tie.
  logic                    last_q;
  logic                    grant_q;
  logic [2:0]              op_q;
  logic [OP_WIDTH-1:0]     a_q, b_q;
  logic [RESULT_WIDTH-1:0] res0_q, res1_q;
  logic                    done0_q, done1_q;
  logic                    tmo_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    accept0, accept1;
  logic                    cap_result;
  logic                    nc_done;
  logic                    tmo_hit;
  logic                    in_wait;
  logic                    compute_op;

  // Only ops 1..4 produce an alu_done; the rest just cycle alu_ready.
  assign compute_op = (op_q >= 3'd1) && (op_q <= 3'd4);
  assign in_wait    = (state_q == WAIT_ACK) || (state_q == WAIT_DONE) ||
                      (state_q == WAIT_RDY);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_valid  = 1'b0;
    accept0    = 1'b0;
    accept1    = 1'b0;
    cap_result = 1'b0;
    nc_done    = 1'b0;
    tmo_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        // Ready is held low during reset so no output leaks a 1 while rst is high.
        if (!rst) begin
          req0_ready = alu_ready && !(req1_valid && (last_q == 1'b0));
          req1_ready = alu_ready && !(req0_valid && (last_q == 1'b1));
        end
        accept0 = req0_valid && req0_ready;
        accept1 = req1_valid && req1_ready;
        if (accept0 || accept1) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        alu_valid = 1'b1;
        state_d   = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (!alu_ready) begin
          state_d = compute_op ? WAIT_DONE : WAIT_RDY;
        end
      end

      WAIT_DONE: begin
        if (alu_done) begin
          cap_result = 1'b1;
          state_d    = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        if (alu_ready) begin
          nc_done = !compute_op;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A normal exit on the final counted cycle takes precedence over timeout.
    if (in_wait && (state_d == state_q) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
      tmo_hit = 1'b1;
      state_d = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath, arbitration pointer, completion and wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      op_q    <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      tmo_q   <= tmo_hit;

      if (accept0) begin
        op_q    <= req0_op;
        a_q     <= req0_a;
        b_q     <= req0_b;
        grant_q <= 1'b0;
        last_q  <= 1'b0;
      end else if (accept1) begin
        op_q    <= req1_op;
        a_q     <= req1_a;
        b_q     <= req1_b;
        grant_q <= 1'b1;
        last_q  <= 1'b1;
      end

      if (cap_result) begin
        if (grant_q) begin
          res1_q  <= alu_result;
          done1_q <= 1'b1;
        end else begin
          res0_q  <= alu_result;
          done0_q <= 1'b1;
        end
      end else if (nc_done) begin
        if (grant_q) begin
          res1_q  <= '0;
          done1_q <= 1'b1;
        end else begin
          res0_q  <= '0;
          done0_q <= 1'b1;
        end
      end

      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (in_wait) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign grant       = grant_q;
  assign timeout_err = tmo_q;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign req0_done   = done0_q;
  assign req1_done   = done1_q;
  assign req0_result = res0_q;
  assign req1_result = res1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. The bench plays the ALU itself: it drops
// alu_ready after an issue, pulses alu_done for ops 1..4, and raises
// alu_ready again. Expected results are hand-computed constants in the
// vector table. Inputs are driven and outputs sampled just after negedge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int OPW = 8;
  localparam int RW  = 16;
  localparam int TMO = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req0_ready, req0_done;
  logic [2:0]     req0_op;
  logic [OPW-1:0] req0_a, req0_b;
  logic [RW-1:0]  req0_result;
  logic           req1_valid, req1_ready, req1_done;
  logic [2:0]     req1_op;
  logic [OPW-1:0] req1_a, req1_b;
  logic [RW-1:0]  req1_result;
  logic           alu_ready, alu_valid, alu_done;
  logic [2:0]     alu_op;
  logic [OPW-1:0] alu_a, alu_b;
  logic [RW-1:0]  alu_result;
  logic           busy, grant, timeout_err;

  always #5 clk = ~clk;

  alu_arbiter #(.OP_WIDTH(OPW), .RESULT_WIDTH(RW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_done(req0_done), .req0_result(req0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_done(req1_done), .req1_result(req1_result),
    .alu_ready(alu_ready), .alu_valid(alu_valid), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_done0  = 0;
  int n_done1  = 0;
  int n_tmo    = 0;

  always @(negedge clk) begin
    if (alu_valid)   n_valid++;
    if (req0_done)   n_done0++;
    if (req1_done)   n_done1++;
    if (timeout_err) n_tmo++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behaviour of the ALU the bench stands in for.
  function automatic logic [RW-1:0] alu_calc(input logic [2:0] op, input logic [OPW-1:0] a,
                                             input logic [OPW-1:0] b);
    case (op)
      3'd1:    return RW'(a) + RW'(b);
      3'd2:    return RW'(a) - RW'(b);
      3'd3:    return RW'(a & b);
      3'd4:    return RW'(a) * RW'(b);
      default: return '0;
    endcase
  endfunction

  function automatic logic get_ready(input int idx);
    return (idx == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic get_done(input int idx);
    return (idx == 0) ? req0_done : req1_done;
  endfunction

  function automatic logic [RW-1:0] get_result(input int idx);
    return (idx == 0) ? req0_result : req1_result;
  endfunction

  task automatic drive_req(input int idx, input logic v, input logic [2:0] op,
                           input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    if (idx == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // Called just after the negedge preceding the accepting posedge. Returns
  // just after the negedge on which the DUT is back in IDLE.
  task automatic run_txn(input int idx, input logic [2:0] op, input logic [OPW-1:0] a,
                         input logic [OPW-1:0] b, input logic [RW-1:0] exp,
                         input bit keep, input int lat);
    int v0, d0, d1;
    bit compute;
    compute = (op >= 3'd1) && (op <= 3'd4);
    v0 = n_valid; d0 = n_done0; d1 = n_done1;

    @(negedge clk); #1;
    chk("issue_valid", alu_valid, 1'b1);
    chk("issue_payload", {alu_op, alu_a, alu_b}, {op, a, b});
    chk("issue_grant", grant, idx);
    chk("ready_low_busy", {req0_ready, req1_ready}, 2'b00);
    if (!keep) drive_req(idx, 1'b0, ~op, ~a, ~b);
    alu_ready = 1'b0;

    @(negedge clk); #1;
    chk("ack_valid_low", alu_valid, 1'b0);
    chk("payload_held", {alu_op, alu_a, alu_b}, {op, a, b});

    if (compute) begin
      @(negedge clk); #1;
      repeat (lat) begin
        @(negedge clk); #1;
      end
      chk("no_early_done", get_done(idx), 1'b0);
      alu_done   = 1'b1;
      alu_result = alu_calc(op, a, b);
      @(negedge clk); #1;
      alu_done   = 1'b0;
      alu_result = 16'hDEAD;
      chk("done_pulse", get_done(idx), 1'b1);
      chk("done_result", get_result(idx), exp);
      chk("other_done_low", get_done(1 - idx), 1'b0);
      alu_ready = 1'b1;
      @(negedge clk); #1;
      chk("done_one_shot", get_done(idx), 1'b0);
      chk("result_held", get_result(idx), exp);
    end else begin
      @(negedge clk); #1;
      repeat (lat) begin
        @(negedge clk); #1;
      end
      chk("no_done_while_busy", get_done(idx), 1'b0);
      alu_ready = 1'b1;
      @(negedge clk); #1;
      chk("nc_done_pulse", get_done(idx), 1'b1);
      chk("nc_done_result", get_result(idx), exp);
    end
    chk("idle_after", busy, 1'b0);
    chk("valid_count", n_valid - v0, 1);
    chk("own_done_count", (idx == 0) ? (n_done0 - d0) : (n_done1 - d1), 1);
    chk("other_done_count", (idx == 0) ? (n_done1 - d1) : (n_done0 - d0), 0);
  endtask

  typedef struct {
    int             idx;
    logic [2:0]     op;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [RW-1:0]  exp;
    int             lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, d0, d1, t0, cyc;

    vecs[0] = '{0, 3'd1, 8'h05, 8'h03, 16'h0008, 4};
    vecs[1] = '{1, 3'd4, 8'h03, 8'h04, 16'h000C, 1};
    vecs[2] = '{0, 3'd2, 8'h09, 8'h04, 16'h0005, 0};
    vecs[3] = '{1, 3'd3, 8'hF0, 8'h3C, 16'h0030, 2};
    vecs[4] = '{0, 3'd0, 8'hAA, 8'h55, 16'h0000, 3};
    vecs[5] = '{1, 3'd7, 8'h12, 8'h34, 16'h0000, 1};
    vecs[6] = '{0, 3'd4, 8'hFF, 8'hFF, 16'hFE01, 5};

    rst = 1'b1;
    drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    drive_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    alu_ready  = 1'b1;
    alu_done   = 1'b0;
    alu_result = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_outputs", {alu_valid, req0_done, req1_done, timeout_err, alu_op, alu_a, alu_b}, 0);
    chk("rst_results", {req0_result, req1_result}, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Single-requester transactions from the vector table.
    for (int i = 0; i < 7; i++) begin
      drive_req(vecs[i].idx, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk("accept_ready", get_ready(vecs[i].idx), 1'b1);
      run_txn(vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, vecs[i].lat);
    end

    // req0 was served last, so req1 wins a tie; withdrawn before the edge.
    drive_req(0, 1'b1, 3'd1, 8'h01, 8'h01);
    drive_req(1, 1'b1, 3'd1, 8'h01, 8'h01);
    #1;
    chk("rr_tie_after_req0", {req0_ready, req1_ready}, 2'b01);
    drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    drive_req(1, 1'b0, 3'd0, 8'h00, 8'h00);

    // Timeout: op 2 never completes.
    @(negedge clk); #1;
    drive_req(0, 1'b1, 3'd2, 8'h10, 8'h01);
    #1;
    chk("tmo_accept_ready", req0_ready, 1'b1);
    d0 = n_done0; d1 = n_done1; t0 = n_tmo;
    @(negedge clk); #1;
    drive_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
    alu_ready = 1'b0;
    @(negedge clk); #1;
    cyc = 0;
    while (timeout_err !== 1'b1 && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("tmo_cycles", cyc, 33);
    chk("tmo_idle", busy, 1'b0);
    @(negedge clk); #1;
    chk("tmo_one_shot", timeout_err, 1'b0);
    chk("tmo_count", n_tmo - t0, 1);
    chk("tmo_no_done", (n_done0 - d0) + (n_done1 - d1), 0);
    alu_ready = 1'b1;
    @(negedge clk); #1;

    // Reset in WAIT_DONE, then a late alu_done while IDLE.
    drive_req(1, 1'b1, 3'd1, 8'h20, 8'h02);
    #1;
    chk("rst_txn_ready", req1_ready, 1'b1);
    d0 = n_done0; d1 = n_done1;
    @(negedge clk); #1;
    chk("rst_txn_grant", grant, 1'b1);
    drive_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
    alu_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_txn_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_grant", grant, 1'b0);
    chk("rst_mid_result0", req0_result, 16'h0000);
    chk("rst_mid_alu_payload", {alu_op, alu_a, alu_b}, 0);
    drive_req(0, 1'b1, 3'd1, 8'h01, 8'h01);
    alu_ready = 1'b1;
    #1;
    chk("rst_mid_ready_held", req0_ready, 1'b0);
    alu_ready = 1'b0;
    @(negedge clk);
    rst        = 1'b0;
    alu_done   = 1'b1;
    alu_result = 16'h0022;
    #1;
    chk("post_rst_wait_alu", req0_ready, 1'b0);
    @(negedge clk); #1;
    alu_done = 1'b0;
    chk("late_done_ignored_busy", busy, 1'b0);
    chk("late_done_no_pulse", (n_done0 - d0) + (n_done1 - d1), 0);
    chk("late_done_results", {req0_result, req1_result}, 0);
    alu_ready = 1'b1;
    #1;
    chk("post_rst_ready", req0_ready, 1'b1);
    run_txn(0, 3'd1, 8'h01, 8'h01, 16'h0002, 1'b0, 2);

    // Round robin from reset with both requesters valid.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    drive_req(0, 1'b1, 3'd4, 8'h03, 8'h04);
    drive_req(1, 1'b1, 3'd4, 8'h03, 8'h04);
    #1;
    chk("rr_first_tie", {req0_ready, req1_ready}, 2'b10);
    run_txn(0, 3'd4, 8'h03, 8'h04, 16'h000C, 1'b0, 2);
    drive_req(0, 1'b1, 3'd1, 8'h07, 8'h08);
    #1;
    chk("rr_second_tie", {req0_ready, req1_ready}, 2'b01);
    run_txn(1, 3'd4, 8'h03, 8'h04, 16'h000C, 1'b1, 2);
    chk("rr_third_tie", {req0_ready, req1_ready}, 2'b10);
    run_txn(0, 3'd1, 8'h07, 8'h08, 16'h000F, 1'b0, 1);
    chk("rr_req1_again", req1_ready, 1'b1);
    run_txn(1, 3'd4, 8'h03, 8'h04, 16'h000C, 1'b0, 0);

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
